div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle sequencer for the MIPS DIV/DIVU datapath in the execute stage. It accepts a divide request from the EX stage and runs a 32-iteration radix-2 restoring division. It returns the quotient and remainder for HI/LO, and produces the `ready_o` handshake that the hazard unit uses to hold stages F/D/E while a divide is in flight. The EX-stage flush (`annul_i`) aborts a divide at any point.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  divide requested; high while a DIV/DIVU sits in EX.
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU; sampled at accept.
- `opdata1_i`  in  WIDTH  dividend; sampled at accept.
- `opdata2_i`  in  WIDTH  divisor; sampled at accept.
- `annul_i`  in  1  abort the current operation (EX flush/exception).
- `result_o`  out  2*WIDTH  {remainder, quotient}; the upper half goes to HI, the lower half to LO.
- `ready_o`  out  1  result valid; pulses for exactly one cycle.

## Operation
- States: IDLE, ZERO, ON, END; the encoding lives in the package.
- IDLE:
  - `start_i & ~annul_i` accepts the request and latches the operands and `signed_i`.
  - If the divisor is 0, go to ZERO; otherwise go to ON and clear the iteration counter.
- ZERO: go to END after one cycle with the result forced to 0.
- ON:
  - Each cycle performs one restoring step on a 2*WIDTH+1-bit partial-remainder/quotient register.
  - Step: shift left by 1, trial-subtract the divisor from the upper WIDTH+1 bits; if the result is non-negative, keep it and set the quotient LSB to 1, else restore and set it to 0.
  - After `WIDTH` steps, go to END.
- END: `ready_o` = 1 and `result_o` is valid; return to IDLE unconditionally on the next cycle.
- Signed handling (`signed_i` = 1):
  - Operands are converted to magnitudes (two's complement) at accept.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Divide by zero: result 0 for both halves; this is the architecturally UNPREDICTABLE case, defined here as 0.
- Abort:
  - `annul_i`, or `start_i` dropping while in ZERO or ON, forces IDLE on the next edge.
  - No `ready_o` is issued and `result_o` is left unchanged.
- `annul_i` has priority over accept and completion.

## Timing
- Reset: state = IDLE, `ready_o` = 0, `result_o` = 0, counter = 0; all asynchronous on `resetn` low.
- Accept at edge T (state IDLE, `start_i` = 1):
  - Non-zero divisor: ON covers T+1 … T+32, and `ready_o` = 1 during the cycle after edge T+32 (END).
  - Zero divisor: `ready_o` = 1 in the cycle after edge T+1.
- `result_o` stays stable from END until the next completed operation; HI/LO writeback samples it when `ready_o` = 1.
- Back-to-back divides:
  - END → IDLE costs one cycle.
  - A new DIV already in EX with `start_i` high is accepted in that IDLE cycle; `ready_o` is 0 there, so the hazard stall stays asserted.
- Throughput: one divide per 34 cycles (non-zero divisor).

## Structure
- Shared package `div_pkg` holds:
  - the state typedef/constants (IDLE, ZERO, ON, END);
  - `DIV_CONTROL` and `DIVU_CONTROL` ALU codes;
  - the `WIDTH` default.
- One sub-module, `div_step`: combinational single restoring iteration (partial register in, divisor in → next partial register, quotient bit). The sequencer owns the FSM, counter, sign fix-up and output register.

## Test plan
- DIVU 100 / 7, accept at T → `ready_o` only in the cycle after edge T+32; `result_o` = {0x00000002, 0x0000000E}.
- DIV −7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}; DIVU 5 / 0 → `ready_o` in the cycle after edge T+1, result 0.
- DIVU 0xFFFFFFFF / 0x10, then `annul_i` pulsed at cycle T+10 → IDLE at T+11, no `ready_o`, `result_o` unchanged; a fresh DIVU 9 / 3 then completes with {0, 3}.
- Two back-to-back DIVU ops with `start_i` held high → two `ready_o` pulses 34 cycles apart, each with the correct result.
- `resetn` driven low at T+15 of an active divide → outputs 0 and state IDLE immediately; after release, the next request completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divide sequencer.
// Holds the FSM state type, the ALU control codes for DIV/DIVU, and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // ALU operation codes decoded in ID that select the divider in EX
    localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
    localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ZERO = 2'b01,
        S_ON   = 2'b10,
        S_END  = 2'b11
    } div_state_t;

    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == DIV_CONTROL) || (aluop == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage (master) and the divide sequencer (slave).
interface div_seq_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One combinational restoring-division iteration on the {remainder, dividend/quotient} register.
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH:0]   i_part,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH:0]   o_part_next,
    output logic               o_qbit
);

    // Upper bits after the left shift; the extra top bit keeps the trial sign exact.
    logic [WIDTH+1:0] w_upper;
    logic [WIDTH+1:0] w_trial;

    assign w_upper = i_part[2*WIDTH:WIDTH-1];
    assign w_trial = w_upper - {2'b00, i_divisor};
    assign o_qbit  = ~w_trial[WIDTH+1];

    assign o_part_next = {(o_qbit ? w_trial[WIDTH:0] : w_upper[WIDTH:0]),
                          i_part[WIDTH-2:0],
                          o_qbit};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: 32 restoring steps, sign fix-up, one-cycle ready pulse.
// An EX flush or a dropped request abandons the operation without touching the result.
module div_seq import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       resetn,
    div_seq_if.slave   bus
);

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*WIDTH:0]      r_part;
    logic [WIDTH-1:0]      r_divisor;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [2*WIDTH-1:0]    r_result;
    logic                  r_ready;

    logic                  w_op1_neg;
    logic                  w_op2_neg;
    logic [WIDTH-1:0]      w_mag1;
    logic [WIDTH-1:0]      w_mag2;
    logic [2*WIDTH:0]      w_part_next;
    logic                  w_qbit;
    logic [WIDTH-1:0]      w_quo_raw;
    logic [WIDTH-1:0]      w_rem_raw;
    logic [WIDTH-1:0]      w_quo_fix;
    logic [WIDTH-1:0]      w_rem_fix;
    logic                  w_abort;

    // Operands become magnitudes at accept; signs are re-applied on the final step.
    assign w_op1_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign w_op2_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign w_mag1    = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_mag2    = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_part      (r_part),
        .i_divisor   (r_divisor),
        .o_part_next (w_part_next),
        .o_qbit      (w_qbit)
    );

    assign w_quo_raw = {w_part_next[WIDTH-1:1], w_qbit};
    assign w_rem_raw = w_part_next[2*WIDTH-1:WIDTH];
    assign w_quo_fix = r_neg_q ? -w_quo_raw : w_quo_raw;
    assign w_rem_fix = r_neg_r ? -w_rem_raw : w_rem_raw;

    assign w_abort = bus.annul_i | ~bus.start_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_part    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        r_part    <= {{(WIDTH+1){1'b0}}, w_mag1};
                        r_divisor <= w_mag2;
                        r_neg_q   <= w_op1_neg ^ w_op2_neg;
                        r_neg_r   <= w_op1_neg;
                        r_cnt     <= '0;
                        r_state   <= (bus.opdata2_i == '0) ? S_ZERO : S_ON;
                    end
                end
                S_ZERO: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= S_END;
                    end
                end
                S_ON: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_part <= w_part_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_STEP) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                            r_state  <= S_END;
                        end
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Directed plus randomized checks of div_seq against an arithmetic quotient/remainder model.
module tb_div_seq;
    import div_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_seq_if #(.WIDTH(W)) bus();

    div_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, remainder follows dividend.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.annul_i   = 1'b0;
        bus.start_i   = 1'b1;
    endtask

    // First edge is the accept edge; n counts edges after it until ready is seen.
    task automatic wait_ready(output int n);
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ready_o !== 1'b1 && n < 80);
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check64({tag, "_pulse"}, {63'd0, bus.ready_o}, 64'd0);
    endtask

    task automatic run_one(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(sgn, a, b);
        wait_ready(n);
        check64({tag, "_lat"}, 64'(n), (b == 32'd0) ? 64'd1 : 64'd32);
        check64({tag, "_res"}, bus.result_o, ref_div(sgn, a, b));
        $display("div %s sgn=%0d a=%h b=%h result=%h lat=%0d", tag, sgn, a, b, bus.result_o, n);
        finish_op(tag);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o === 1'b1) pulses++;
        end
    endtask

    initial begin
        int          n;
        int          pulses;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;

        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.annul_i   = 1'b0;

        repeat (3) @(negedge clk);
        check64("rst_ready", {63'd0, bus.ready_o}, 64'd0);
        check64("rst_result", bus.result_o, 64'd0);
        check64("rst_state", 64'(dut.r_state), 64'(S_IDLE));
        resetn = 1'b1;

        run_one("divu_100_7", 1'b0, 32'd100, 32'd7);
        check64("divu_100_7_const", bus.result_o, 64'h00000002_0000000E);
        run_one("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2);
        check64("div_m7_2_const", bus.result_o, 64'hFFFFFFFF_FFFFFFFD);
        run_one("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        check64("div_min_m1_const", bus.result_o, 64'h00000000_80000000);

        // Flush at T+11 of a running divide
        issue(1'b0, 32'hFFFFFFFF, 32'h10);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        check64("annul_state", 64'(dut.r_state), 64'(S_IDLE));
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        count_pulses(40, pulses);
        check64("annul_no_ready", 64'(pulses), 64'd0);
        check64("annul_result_kept", bus.result_o, 64'h00000000_80000000);
        $display("div annul a=ffffffff b=00000010 pulses=%0d result=%h", pulses, bus.result_o);

        run_one("divu_9_3", 1'b0, 32'd9, 32'd3);
        check64("divu_9_3_const", bus.result_o, 64'h00000000_00000003);
        run_one("divu_5_0", 1'b0, 32'd5, 32'd0);
        check64("divu_5_0_const", bus.result_o, 64'd0);

        // Request withdrawn mid-divide
        issue(1'b0, 32'd1234567, 32'd89);
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        count_pulses(40, pulses);
        check64("drop_no_ready", 64'(pulses), 64'd0);
        check64("drop_result_kept", bus.result_o, 64'd0);
        $display("div drop a=0012d687 b=00000059 pulses=%0d result=%h", pulses, bus.result_o);

        // Back-to-back with start held high
        issue(1'b0, 32'd1000, 32'd3);
        wait_ready(n);
        check64("b2b_first_lat", 64'(n), 64'd32);
        check64("b2b_first_res", bus.result_o, ref_div(1'b0, 32'd1000, 32'd3));
        $display("div b2b_first a=000003e8 b=00000003 result=%h lat=%0d", bus.result_o, n);
        @(negedge clk);
        bus.opdata1_i = 32'd77777;
        bus.opdata2_i = 32'd10;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ready_o !== 1'b1 && n < 80);
        check64("b2b_spacing", 64'(n), 64'd34);
        check64("b2b_second_res", bus.result_o, ref_div(1'b0, 32'd77777, 32'd10));
        $display("div b2b_second a=00012fd1 b=0000000a result=%h spacing=%0d", bus.result_o, n);
        finish_op("b2b");

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = (i % 7 == 3) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 300);
                2:       b = 32'hFFFFFFFF - $urandom_range(0, 50);
                default: b = (i % 6 == 0) ? 32'd0 : $urandom_range(1, 16);
            endcase
            run_one($sformatf("rnd%0d", i), sgn, a, b);
        end

        // Asynchronous reset in the middle of a divide
        run_one("pre_rst", 1'b0, 32'd100, 32'd7);
        issue(1'b0, 32'hFFFFFFFF, 32'd7);
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check64("arst_ready", {63'd0, bus.ready_o}, 64'd0);
        check64("arst_result", bus.result_o, 64'd0);
        check64("arst_state", 64'(dut.r_state), 64'(S_IDLE));
        @(negedge clk);
        resetn = 1'b1;
        wait_ready(n);
        check64("post_rst_lat", 64'(n), 64'd32);
        check64("post_rst_res", bus.result_o, ref_div(1'b0, 32'hFFFFFFFF, 32'd7));
        $display("div post_rst a=ffffffff b=00000007 result=%h lat=%0d", bus.result_o, n);
        finish_op("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
